// File: rtl/icache_pkg.sv
// Shared types and helpers for the set-associative instruction cache:
// FSM state, address-field widths and tree-PLRU victim/update functions.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    REPLAY,
    FLUSH
  } state_t;

  function automatic int off_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int line_bits, input int sets);
    return 32 - idx_bits(sets) - off_bits(line_bits);
  endfunction

  // Tree stored heap-style: node n has children 2n+1 / 2n+2; bit 0 points left.
  function automatic logic [2:0] plru_victim(input logic [6:0] tree, input int levels);
    logic [3:0] node;
    logic [2:0] way;
    logic       b;
    node = '0;
    way  = '0;
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        b    = tree[node[2:0]];
        way  = {way[1:0], b};
        node = {node[2:0], 1'b0} + 4'd1 + {3'b000, b};
      end
    end
    return way;
  endfunction

  function automatic logic [6:0] plru_touch(input logic [6:0] tree, input logic [2:0] way,
                                            input int levels);
    logic [3:0] node;
    logic [2:0] w;
    logic [6:0] t;
    logic       b;
    t    = tree;
    node = '0;
    w    = way << (3 - levels);
    for (int l = 0; l < 3; l++) begin
      if (l < levels) begin
        b              = w[2];
        t[node[2:0]]   = ~b;
        node           = {node[2:0], 1'b0} + 4'd1 + {3'b000, b};
        w              = w << 1;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree-PLRU state for the instruction cache; reports the PLRU victim
// of the addressed set and records accesses to it.
module icache_plru
  import icache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [$clog2(SETS)-1:0] set_idx,
  input  logic                    access_valid,
  input  logic [$clog2(WAYS)-1:0] access_way,
  output logic [$clog2(WAYS)-1:0] victim_way
);

  localparam int WB = $clog2(WAYS);

  logic [WAYS-2:0] tree_reg [SETS];
  logic [6:0]      tree_cur;
  logic [6:0]      touched;
  logic [2:0]      vic_full;
  logic            unused_bits;

  assign tree_cur    = 7'(tree_reg[set_idx]);
  assign touched     = plru_touch(tree_cur, 3'(access_way), WB);
  assign vic_full    = plru_victim(tree_cur, WB);
  assign victim_way  = vic_full[WB-1:0];
  assign unused_bits = ^{touched, vic_full};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int s = 0; s < SETS; s++) tree_reg[s] <= '0;
    end else if (access_valid) begin
      tree_reg[set_idx] <= touched[WAYS-2:0];
    end
  end

endmodule

// File: rtl/icache_nway.sv
// Read-only N-way set-associative instruction cache with blocking miss path,
// flush and back-to-back hits. Optional hit/miss counters: ICACHE_STATS_EN.
module icache_nway
  import icache_pkg::*;
#(
  parameter int WAYS      = 4,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ufp_addr,
  input  logic [3:0]           ufp_rmask,
  input  logic [3:0]           ufp_wmask,
  output logic [31:0]          ufp_rdata,
  output logic                 ufp_resp,
  input  logic                 flush,
  output logic [31:0]          dfp_addr,
  output logic                 dfp_read,
  output logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  output logic [LINE_BITS-1:0] dfp_wdata,
  input  logic                 dfp_resp
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int OFF  = off_bits(LINE_BITS);
  localparam int IDX  = idx_bits(SETS);
  localparam int TAG  = tag_bits(LINE_BITS, SETS);
  localparam int WB   = $clog2(WAYS);
  localparam int WSEL = OFF - 2;

  state_t            state_reg, state_next;
  logic [IDX-1:0]    idx_reg;
  logic [TAG-1:0]    tag_reg;
  logic [WSEL-1:0]   word_reg;
  logic              write_reg;
  logic              flush_pend_reg;
  logic              req, accept, resp, fill_we, hit, plru_access, plru_clear;
  logic [IDX-1:0]    rd_idx;
  logic [WAYS-1:0]   way_hit, valid_cur;
  logic [WAYS-1:0][31:0] way_word;
  logic [31:0]       hit_word;
  logic [WB-1:0]     hit_way, plru_way, fill_way, plru_acc_way;
  logic              unused_addr_bits;

  assign req              = (|ufp_rmask) || (|ufp_wmask);
  assign rd_idx           = accept ? ufp_addr[OFF+IDX-1:OFF] : idx_reg;
  assign hit              = |way_hit;
  assign unused_addr_bits = ^ufp_addr[1:0];

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    resp       = 1'b0;
    fill_we    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush) begin
          state_next = FLUSH;
        end else if (req) begin
          accept     = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (write_reg || hit) begin
          resp = 1'b1;
          if (flush || flush_pend_reg) state_next = FLUSH;
          else if (req) accept = 1'b1;
          else state_next = IDLE;
        end else begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (dfp_resp) begin
          fill_we    = 1'b1;
          state_next = REPLAY;
        end
      end
      REPLAY:  state_next = LOOKUP;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      tag_reg        <= '0;
      word_reg       <= '0;
      write_reg      <= 1'b0;
      flush_pend_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        idx_reg   <= ufp_addr[OFF+IDX-1:OFF];
        tag_reg   <= ufp_addr[31:OFF+IDX];
        word_reg  <= ufp_addr[OFF-1:2];
        write_reg <= ~|ufp_rmask;
      end
      // A flush mid-transaction waits until the outstanding response is out.
      if (state_next == FLUSH) flush_pend_reg <= 1'b0;
      else if (flush && (state_reg inside {LOOKUP, FILL, REPLAY})) flush_pend_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [LINE_BITS-1:0] data_mem [SETS];
      logic [TAG-1:0]       tag_mem  [SETS];
      logic [LINE_BITS-1:0] data_q;
      logic [TAG-1:0]       tag_q;
      logic [SETS-1:0]      valid_reg;
      logic                 way_we;

      assign way_we = fill_we && (fill_way == WB'(gi));

      always_ff @(posedge clk) begin
        if (way_we) begin
          data_mem[idx_reg] <= dfp_rdata;
          tag_mem[idx_reg]  <= tag_reg;
        end
        data_q <= data_mem[rd_idx];
        tag_q  <= tag_mem[rd_idx];
      end

      always_ff @(posedge clk) begin
        if (rst || state_reg == FLUSH) valid_reg <= '0;
        else if (way_we) valid_reg[idx_reg] <= 1'b1;
      end

      assign valid_cur[gi] = valid_reg[idx_reg];
      assign way_hit[gi]   = valid_reg[idx_reg] && (tag_q == tag_reg);
      assign way_word[gi]  = way_hit[gi] ? data_q[{word_reg, 5'b00000} +: 32] : 32'h0;
    end
  endgenerate

  always_comb begin
    hit_word = '0;
    hit_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_word = hit_word | way_word[w];
      if (way_hit[w]) hit_way = WB'(w);
    end
  end

  // Empty ways are refilled before the PLRU choice is consulted.
  always_comb begin
    fill_way = plru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_cur[w]) fill_way = WB'(w);
    end
  end

  assign plru_access  = fill_we || (state_reg == LOOKUP && !write_reg && hit);
  assign plru_acc_way = fill_we ? fill_way : hit_way;
  assign plru_clear   = (state_reg == FLUSH);

  icache_plru #(
    .WAYS(WAYS),
    .SETS(SETS)
  ) u_plru (
    .clk         (clk),
    .rst         (rst),
    .clear       (plru_clear),
    .set_idx     (idx_reg),
    .access_valid(plru_access),
    .access_way  (plru_acc_way),
    .victim_way  (plru_way)
  );

  assign ufp_resp  = resp;
  assign ufp_rdata = (resp && !write_reg) ? hit_word : 32'h0;
  assign dfp_read  = (state_reg == FILL);
  assign dfp_addr  = dfp_read ? {tag_reg, idx_reg, {OFF{1'b0}}} : 32'h0;
  assign dfp_write = 1'b0;
  assign dfp_wdata = '0;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;
  logic        replay_reg;
  logic        first_lookup;

  assign first_lookup = (state_reg == LOOKUP) && !replay_reg && !write_reg;

  always_ff @(posedge clk) begin
    if (rst || state_reg == FLUSH) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
      replay_reg   <= 1'b0;
    end else begin
      replay_reg <= (state_reg == REPLAY);
      if (first_lookup && hit && hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      if (first_lookup && !hit && miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_reg;
  assign miss_count = miss_cnt_reg;
`endif

endmodule
